rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8.sv | 152 +++++++++++++++
 tb/tb_rr_arbiter_8.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, per-owner hold limit
// and a mandatory idle gap between owners. Includes a port-level property checker.

module rr_arbiter_8 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       EN,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    // Returns {found, index} of the first set request at or above p, wrapping 7->0.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] decode3(input logic [2:0] idx);
        return 8'(8'd1 << idx);
    endfunction

    logic [1:0] state_r, state_nxt_s;
    logic [2:0] ptr_r, ptr_nxt_s;
    logic [7:0] hold_cnt_r, hold_nxt_s;
    logic [7:0] gnt_r, gnt_nxt_s;
    logic [2:0] gnt_idx_r, idx_nxt_s;
    logic       gnt_valid_r, valid_nxt_s;
    logic [3:0] pick_s;
    logic       exit_s;

    assign pick_s = rr_pick(req, ptr_r);

    // Release condition for the current owner; any mix of causes yields one release.
    always_comb begin
        exit_s = done | ~req[gnt_idx_r] | (hold_cnt_r == HOLD_LAST) | ~EN;
    end

    // Next-state and next-output logic for the IDLE / GRANT / GAP sequence.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        hold_nxt_s  = hold_cnt_r;
        gnt_nxt_s   = gnt_r;
        idx_nxt_s   = gnt_idx_r;
        valid_nxt_s = gnt_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (EN && pick_s[3]) begin
                    state_nxt_s = ST_GRANT;
                    idx_nxt_s   = pick_s[2:0];
                    gnt_nxt_s   = decode3(pick_s[2:0]);
                    valid_nxt_s = 1'b1;
                    hold_nxt_s  = 8'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = 8'h00;
                    valid_nxt_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (exit_s) begin
                    state_nxt_s = ST_GAP;
                    ptr_nxt_s   = gnt_idx_r + 3'd1;
                    hold_nxt_s  = 8'd0;
                    gnt_nxt_s   = 8'h00;
                    valid_nxt_s = 1'b0;
                end else begin
                    hold_nxt_s  = hold_cnt_r + 8'd1;
                end
            end
            ST_GAP: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = 8'h00;
                valid_nxt_s = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                hold_nxt_s  = 8'd0;
                gnt_nxt_s   = 8'h00;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears the grant without a GAP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'd0;
            hold_cnt_r  <= 8'd0;
            gnt_r       <= 8'h00;
            gnt_idx_r   <= 3'd0;
            gnt_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_idx_r   <= idx_nxt_s;
            gnt_valid_r <= valid_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;

endmodule

// Port-level grant properties; attach alongside an rr_arbiter_8 instance.
module rr_arbiter_8_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [7:0] gnt,
    input logic [2:0] gnt_idx,
    input logic       gnt_valid
);

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

    a_decode: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid |-> (gnt == 8'(8'd1 << gnt_idx)));

    a_zero_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !gnt_valid |-> (gnt == 8'h00));

    // An owner can only change after at least one cycle with no grant.
    a_handover: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_valid |=> (!gnt_valid || $stable(gnt_idx)));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: vector table, directed corner sequences
// and randomized traffic against a cycle-level behavioural model.

module tb_rr_arbiter_8;

    localparam int HM = 8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       done;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: current owner (-1 = none), cycles held, last owner,
    // search start, and whether the one-cycle release gap is still pending.
    int m_owner;
    int m_held;
    int m_last;
    int m_ptr;
    int m_cool;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } vec_t;

    vec_t tbl[14];

    rr_arbiter_8 #(.HOLD_MAX(HM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EN       (en),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    rr_arbiter_8_chk chk_u (
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 0;
        m_ptr   = 0;
        m_cool  = 0;
    endtask

    task automatic model_update(input logic e, input logic [7:0] r, input logic d);
        bit found;
        if (m_owner >= 0) begin
            m_held++;
            if (d || !r[m_owner] || m_held == HM || !e) begin
                m_last  = m_owner;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_cool  = 1;
            end
        end else if (m_cool != 0) begin
            m_cool = 0;
        end else if (e && r != 8'h00) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && r[(m_ptr + k) % 8]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % 8;
                end
            end
            m_last = m_owner;
            m_held = 0;
        end
    endtask

    task automatic compare_model();
        logic [7:0] eg;
        logic [2:0] ei;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        ei = 3'(m_last);
        chk("model", {20'd0, gnt, gnt_idx, gnt_valid}, {20'd0, eg, ei, (m_owner >= 0)});
    endtask

    // One clock: capture the applied inputs, let the edge happen, then compare.
    task automatic step();
        logic e;
        logic d;
        logic [7:0] r;
        e = en;
        d = done;
        r = req;
        @(posedge clk);
        #1;
        model_update(e, r, d);
        compare_model();
    endtask

    // Called away from a clock edge so the zero outputs prove the reset is asynchronous.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_reset", {20'd0, gnt, gnt_idx, gnt_valid}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int zeros;
        int len;

        rst_n = 1'b1;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        model_reset();

        tbl[0]  = '{1'b1, 8'h24, 1'b0, 8'h04, 3'd2, 1'b1};
        tbl[1]  = '{1'b1, 8'h24, 1'b0, 8'h04, 3'd2, 1'b1};
        tbl[2]  = '{1'b1, 8'h24, 1'b1, 8'h00, 3'd2, 1'b0};
        tbl[3]  = '{1'b1, 8'h24, 1'b0, 8'h00, 3'd2, 1'b0};
        tbl[4]  = '{1'b1, 8'h24, 1'b0, 8'h20, 3'd5, 1'b1};
        tbl[5]  = '{1'b1, 8'h24, 1'b0, 8'h20, 3'd5, 1'b1};
        tbl[6]  = '{1'b1, 8'h24, 1'b1, 8'h00, 3'd5, 1'b0};
        tbl[7]  = '{1'b1, 8'h24, 1'b0, 8'h00, 3'd5, 1'b0};
        tbl[8]  = '{1'b1, 8'h24, 1'b0, 8'h04, 3'd2, 1'b1};
        tbl[9]  = '{1'b0, 8'h24, 1'b0, 8'h00, 3'd2, 1'b0};
        tbl[10] = '{1'b0, 8'h24, 1'b0, 8'h00, 3'd2, 1'b0};
        tbl[11] = '{1'b0, 8'h24, 1'b0, 8'h00, 3'd2, 1'b0};
        tbl[12] = '{1'b1, 8'h24, 1'b0, 8'h20, 3'd5, 1'b1};
        tbl[13] = '{1'b1, 8'h04, 1'b0, 8'h00, 3'd5, 1'b0};

        #2;
        do_reset();
        chk("reset_state", {20'd0, gnt, gnt_idx, gnt_valid}, 32'd0);

        // Table: alternating owners 2/5 with done, EN drop, request withdrawal.
        for (int i = 0; i < 14; i++) begin
            en   = tbl[i].en;
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            chk($sformatf("vec%0d", i), {20'd0, gnt, gnt_idx, gnt_valid},
                {20'd0, tbl[i].gnt, tbl[i].idx, tbl[i].valid});
        end

        // All requesting: owners rotate 0..7,0, each held HOLD_MAX cycles; the
        // handover gap is the GAP cycle plus the IDLE decision cycle.
        do_reset();
        en = 1'b1; req = 8'hFF; done = 1'b0;
        for (int k = 0; k < 9; k++) begin
            zeros = 0;
            step();
            while (!gnt_valid && zeros < 6) begin
                zeros++;
                step();
            end
            chk("rr_owner", {29'd0, gnt_idx}, 32'(k % 8));
            chk("rr_gnt", {24'd0, gnt}, 32'(1 << (k % 8)));
            if (k > 0) chk("rr_gap", 32'(zeros + 1), 32'd2);
            len = 1;
            step();
            while (gnt_valid && len < HM + 4) begin
                len++;
                step();
            end
            chk("rr_len", 32'(len), 32'(HM));
        end

        // Owner 3 drops its request in its fourth grant cycle; next search starts at 4.
        do_reset();
        en = 1'b1; req = 8'h08; done = 1'b0;
        step();
        chk("drop_grant", {24'd0, gnt}, 32'h08);
        repeat (3) step();
        req = 8'h10;
        step();
        chk("drop_gap", {20'd0, gnt, gnt_idx, gnt_valid}, {20'd0, 8'h00, 3'd3, 1'b0});
        req = 8'h18;
        step();
        step();
        chk("drop_ptr", {20'd0, gnt, gnt_idx, gnt_valid}, {20'd0, 8'h10, 3'd4, 1'b1});

        // EN low revokes owner 6 and blocks regrant until EN returns.
        do_reset();
        en = 1'b1; req = 8'h40; done = 1'b0;
        step();
        chk("en_grant", {24'd0, gnt}, 32'h40);
        step();
        en = 1'b0;
        step();
        chk("en_revoke", {20'd0, gnt, gnt_idx, gnt_valid}, {20'd0, 8'h00, 3'd6, 1'b0});
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en_blocked", {31'd0, gnt_valid}, 32'd0);
        end
        en = 1'b1;
        step();
        chk("en_regrant", {24'd0, gnt}, 32'h40);

        // Reset mid-grant of owner 5, then owner 5 is granted again from ptr 0.
        do_reset();
        en = 1'b1; req = 8'h20; done = 1'b0;
        step();
        chk("rst_grant", {24'd0, gnt}, 32'h20);
        step();
        do_reset();
        step();
        chk("rst_regrant", {20'd0, gnt, gnt_idx, gnt_valid}, {20'd0, 8'h20, 3'd5, 1'b1});

        // done coincides with the hold limit: one release, pointer advances by one.
        do_reset();
        en = 1'b1; req = 8'h03; done = 1'b0;
        step();
        chk("lim_grant", {29'd0, gnt_idx}, 32'd0);
        repeat (HM - 1) step();
        chk("lim_still", {31'd0, gnt_valid}, 32'd1);
        done = 1'b1;
        step();
        chk("lim_gap", {31'd0, gnt_valid}, 32'd0);
        done = 1'b0;
        step();
        chk("lim_idle", {31'd0, gnt_valid}, 32'd0);
        step();
        chk("lim_next", {20'd0, gnt, gnt_idx, gnt_valid}, {20'd0, 8'h02, 3'd1, 1'b1});

        // Randomized traffic with occasional resets, checked by the model each cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en   = ($urandom_range(0, 15) != 0);
            req  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = req & 8'($urandom);
            done = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
